arinc_rx_label_ctrl: RTL and testbench
======================================

# arinc_rx_label_ctrl

Receive-side label filter controller for the ARINC429 receiver. Arbitrates between host label-enable requests and incoming 32-bit receive words for the single `Label_Check` table. Each accepted word is sequenced through a table lookup, and words with enabled labels are buffered in a small show-ahead FIFO. Also keeps saturating accept, drop and overflow statistics.

## Interface
Parameters:
- FIFO_DEPTH, 4, receive FIFO entries; power of two, ≥2
- CNT_W, 16, width of each statistics counter

Ports:
- Clk  in  1  system clock, rising edge
- Rst  in  1  asynchronous, active-high reset
- Cfg_req  in  1  host request to enable label Cfg_label; held until Cfg_ack
- Cfg_label  in  8  label to enable
- Cfg_ack  out  1  one-cycle pulse, high in the cycle the table write is issued
- Rx_valid  in  1  receive word available
- Rx_word  in  32  receive word; label = Rx_word[7:0]
- Rx_ready  out  1  controller can accept a word this cycle
- Lc_wr  out  1  to Label_Check Wr
- Lc_label_adr  out  8  to Label_Check Label_adr
- Lc_rd  out  1  to Label_Check Rd
- Lc_label_in  out  8  to Label_Check Label_in
- Lc_label_hit  in  1  from Label_Check Label_out; valid the cycle after Lc_rd
- Out_valid  out  1  FIFO non-empty
- Out_word  out  32  FIFO head word (show-ahead)
- Out_rd  in  1  pop head; ignored when Out_valid=0
- Fifo_full  out  1  FIFO holds FIFO_DEPTH words
- Accept_cnt  out  CNT_W  words with an enabled label pushed into the FIFO
- Drop_cnt  out  CNT_W  words discarded because their label is not enabled
- Ovf_cnt  out  CNT_W  words with an enabled label discarded because the FIFO was full

## Operation
- The FSM has four states: IDLE, WRITE, LOOKUP and DECIDE. Lc_* outputs are registered Moore outputs.
- **IDLE**
  - Rx_ready = 1 only in IDLE.
  - If only Cfg_req is high: latch Cfg_label and go to WRITE.
  - If only Rx_valid is high: latch Rx_word (the handshake is Rx_valid & Rx_ready) and go to LOOKUP.
  - If both are high: round-robin using a 1-bit last_grant flag. After reset, config wins first. When config wins, Rx_ready is deasserted that cycle.
- **WRITE**
  - Lc_wr = 1, Lc_label_adr = latched label, Cfg_ack = 1.
  - Next state is IDLE.
- **LOOKUP**
  - Lc_rd = 1, Lc_label_in = latched word[7:0].
  - Next state is DECIDE.
- **DECIDE**
  - Sample Lc_label_hit.
  - Hit, and (FIFO not full, or Out_rd pops this cycle): push the word and increment Accept_cnt.
  - Hit and FIFO full with no pop: discard the word and increment Ovf_cnt.
  - Miss: discard the word and increment Drop_cnt.
  - Next state is IDLE.
- Lc_wr and Lc_rd are never high together, and each is high in at most one cycle per transaction.
- The FIFO is a circular buffer with log2(FIFO_DEPTH)-bit pointers and a separate occupancy count, so full and empty are unambiguous. Pointers wrap modulo FIFO_DEPTH.
  - Pop decrements occupancy; push increments it.
  - Simultaneous push and pop leaves occupancy unchanged.
  - Out_rd when empty is ignored.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Rst (asynchronous) forces: state IDLE, FIFO empty, all counters 0, last_grant = cfg-next, and all outputs 0 except Out_word (don't-care). Label_Check contents are retained; it has no reset. An in-flight config write or lookup is abandoned and Cfg_ack is not issued.

## Timing
- Rx accept to FIFO push: accept at edge N, LOOKUP in cycle N+1, DECIDE in cycle N+2. Out_valid rises in cycle N+3 if the FIFO was empty.
- Maximum receive throughput is one word per 3 cycles. Config costs 2 cycles (IDLE + WRITE).
- A write issued in WRITE is visible to any subsequent LOOKUP, including one immediately following.
- Out_word is valid whenever Out_valid = 1. A pop takes effect at the edge where Out_rd & Out_valid.
- Lc_label_hit is sampled only in DECIDE and ignored otherwise.

## Test plan
- **Reset:** assert Rst mid-LOOKUP → all outputs 0, Rx_ready = 1 one cycle after release, counters 0.
- **Enable then receive:** Cfg_label = 8'h6A enable, then Rx_word = 32'h1234_566A → Lc_rd one cycle after accept; Out_valid 3 cycles after accept with Out_word = 32'h1234_566A; Accept_cnt = 1.
- **Miss:** receive a word with label 8'h10 (not enabled) → no push, Drop_cnt = 1, Out_valid unchanged.
- **Overflow:** FIFO_DEPTH = 4, label enabled, 5 words with Out_rd = 0 → Fifo_full after 4, Ovf_cnt = 1. Repeat with Out_rd = 1 in the 5th word's DECIDE cycle → push succeeds, Ovf_cnt = 0.
- **Arbitration:** Cfg_req and Rx_valid held together → grants alternate cfg, rx, cfg, rx. Lc_wr and Lc_rd are never both high; Cfg_ack is a single pulse per request.
- **Saturation:** CNT_W = 2, 5 misses → Drop_cnt stays 3. FIFO pointer wrap is exercised with 10 push/pop pairs; data order is preserved.

Source files
------------

// File: rtl/arinc_rx_label_ctrl.sv
// ARINC429 receive label filter controller: arbitrates host label enables against incoming words,
// looks each word up in Label_Check and buffers enabled words in a show-ahead FIFO.
module arinc_rx_label_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Cfg_req,
    input  logic [7:0]       Cfg_label,
    output logic             Cfg_ack,
    input  logic             Rx_valid,
    input  logic [31:0]      Rx_word,
    output logic             Rx_ready,
    output logic             Lc_wr,
    output logic [7:0]       Lc_label_adr,
    output logic             Lc_rd,
    output logic [7:0]       Lc_label_in,
    input  logic             Lc_label_hit,
    output logic             Out_valid,
    output logic [31:0]      Out_word,
    input  logic             Out_rd,
    output logic             Fifo_full,
    output logic [CNT_W-1:0] Accept_cnt,
    output logic [CNT_W-1:0] Drop_cnt,
    output logic [CNT_W-1:0] Ovf_cnt
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CntMax = '1;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StLookup,
        StDecide
    } state_e;

    state_e state_q, state_d;

    logic        cfg_next_q, cfg_next_d;
    logic [31:0] word_q, word_d;

    logic       lc_wr_q, lc_rd_q, cfg_ack_q;
    logic [7:0] lc_adr_q, lc_adr_d;
    logic [7:0] lc_lbl_q, lc_lbl_d;

    logic cfg_win, rx_win;
    logic hit_ok, miss, push, pop, ovf_evt;
    logic full, empty;

    logic [31:0]     mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;

    logic [CNT_W-1:0] acc_q, drop_q, ovf_q;

    // cfg_next_q set means config has priority on the next simultaneous request.
    always_comb begin
        cfg_win = 1'b0;
        rx_win  = 1'b0;
        if (state_q == StIdle) begin
            if (Cfg_req && (!Rx_valid || cfg_next_q)) begin
                cfg_win = 1'b1;
            end else if (Rx_valid) begin
                rx_win = 1'b1;
            end
        end
    end

    assign Rx_ready = (state_q == StIdle) && !cfg_win && !Rst;

    always_comb begin
        state_d    = state_q;
        cfg_next_d = cfg_next_q;
        word_d     = word_q;
        unique case (state_q)
            StIdle: begin
                if (cfg_win) begin
                    state_d    = StWrite;
                    cfg_next_d = 1'b0;
                end else if (rx_win) begin
                    state_d    = StLookup;
                    cfg_next_d = 1'b1;
                    word_d     = Rx_word;
                end
            end
            StWrite:  state_d = StIdle;
            StLookup: state_d = StDecide;
            StDecide: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Label_Check strobes are registered so they coincide with WRITE / LOOKUP.
    always_comb begin
        lc_adr_d = cfg_win ? Cfg_label : 8'h00;
        lc_lbl_d = rx_win ? Rx_word[7:0] : 8'h00;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= StIdle;
            cfg_next_q <= 1'b1;
            word_q     <= 32'h0;
            lc_wr_q    <= 1'b0;
            lc_rd_q    <= 1'b0;
            cfg_ack_q  <= 1'b0;
            lc_adr_q   <= 8'h00;
            lc_lbl_q   <= 8'h00;
        end else begin
            state_q    <= state_d;
            cfg_next_q <= cfg_next_d;
            word_q     <= word_d;
            lc_wr_q    <= cfg_win;
            lc_rd_q    <= rx_win;
            cfg_ack_q  <= cfg_win;
            lc_adr_q   <= lc_adr_d;
            lc_lbl_q   <= lc_lbl_d;
        end
    end

    assign Lc_wr        = lc_wr_q;
    assign Lc_rd        = lc_rd_q;
    assign Cfg_ack      = cfg_ack_q;
    assign Lc_label_adr = lc_adr_q;
    assign Lc_label_in  = lc_lbl_q;

    assign full  = (count_q == FullCnt);
    assign empty = (count_q == '0);

    // A pop in the DECIDE cycle frees a slot for the word being pushed.
    assign hit_ok  = (state_q == StDecide) && Lc_label_hit;
    assign miss    = (state_q == StDecide) && !Lc_label_hit;
    assign pop     = Out_rd && !empty;
    assign push    = hit_ok && (!full || pop);
    assign ovf_evt = hit_ok && full && !pop;

    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= word_q;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign Out_valid = !empty;
    assign Out_word  = mem_q[rd_ptr_q];
    assign Fifo_full = full;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            acc_q  <= '0;
            drop_q <= '0;
            ovf_q  <= '0;
        end else begin
            if (push && (acc_q != CntMax)) begin
                acc_q <= acc_q + 1'b1;
            end
            if (miss && (drop_q != CntMax)) begin
                drop_q <= drop_q + 1'b1;
            end
            if (ovf_evt && (ovf_q != CntMax)) begin
                ovf_q <= ovf_q + 1'b1;
            end
        end
    end

    assign Accept_cnt = acc_q;
    assign Drop_cnt   = drop_q;
    assign Ovf_cnt    = ovf_q;

endmodule

// File: tb/tb_arinc_rx_label_ctrl.sv
// Bench for arinc_rx_label_ctrl: a 16-bit-counter instance and a 2-bit-counter instance share
// stimulus, each with its own Label_Check table model; vectors plus hand-written sequences.
module tb_arinc_rx_label_ctrl;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        cfg_req = 1'b0;
    logic [7:0]  cfg_label = 8'h00;
    logic        rx_valid = 1'b0;
    logic [31:0] rx_word = 32'h0;
    logic        out_rd = 1'b0;

    logic        cfg_ack_a, rx_ready_a, lc_wr_a, lc_rd_a, out_valid_a, fifo_full_a;
    logic [7:0]  lc_adr_a, lc_lbl_a;
    logic [31:0] out_word_a;
    logic [15:0] acc_a, drop_a, ovf_a;
    logic        hit_a = 1'b0;
    logic [255:0] tbl_a = '0;

    logic        cfg_ack_b, rx_ready_b, lc_wr_b, lc_rd_b, out_valid_b, fifo_full_b;
    logic [7:0]  lc_adr_b, lc_lbl_b;
    logic [31:0] out_word_b;
    logic [1:0]  acc_b, drop_b, ovf_b;
    logic        hit_b = 1'b0;
    logic [255:0] tbl_b = '0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    arinc_rx_label_ctrl #(.FIFO_DEPTH(4), .CNT_W(16)) dut_a (
        .Clk(Clk), .Rst(Rst), .Cfg_req(cfg_req), .Cfg_label(cfg_label), .Cfg_ack(cfg_ack_a),
        .Rx_valid(rx_valid), .Rx_word(rx_word), .Rx_ready(rx_ready_a), .Lc_wr(lc_wr_a),
        .Lc_label_adr(lc_adr_a), .Lc_rd(lc_rd_a), .Lc_label_in(lc_lbl_a),
        .Lc_label_hit(hit_a), .Out_valid(out_valid_a), .Out_word(out_word_a), .Out_rd(out_rd),
        .Fifo_full(fifo_full_a), .Accept_cnt(acc_a), .Drop_cnt(drop_a), .Ovf_cnt(ovf_a)
    );

    arinc_rx_label_ctrl #(.FIFO_DEPTH(4), .CNT_W(2)) dut_b (
        .Clk(Clk), .Rst(Rst), .Cfg_req(cfg_req), .Cfg_label(cfg_label), .Cfg_ack(cfg_ack_b),
        .Rx_valid(rx_valid), .Rx_word(rx_word), .Rx_ready(rx_ready_b), .Lc_wr(lc_wr_b),
        .Lc_label_adr(lc_adr_b), .Lc_rd(lc_rd_b), .Lc_label_in(lc_lbl_b),
        .Lc_label_hit(hit_b), .Out_valid(out_valid_b), .Out_word(out_word_b), .Out_rd(out_rd),
        .Fifo_full(fifo_full_b), .Accept_cnt(acc_b), .Drop_cnt(drop_b), .Ovf_cnt(ovf_b)
    );

    // Label_Check models: no reset, hit registered one cycle after Rd.
    always @(posedge Clk) begin
        if (lc_wr_a) tbl_a[lc_adr_a] <= 1'b1;
        if (lc_rd_a) hit_a <= tbl_a[lc_lbl_a];
        if (lc_wr_b) tbl_b[lc_adr_b] <= 1'b1;
        if (lc_rd_b) hit_b <= tbl_b[lc_lbl_b];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sat3(input int v);
        return (v > 3) ? 32'd3 : 32'(v);
    endfunction

    task automatic chk_cnt(input int acc, input int drop, input int ovf);
        chk("accept_cnt", 32'(acc_a), 32'(acc));
        chk("drop_cnt", 32'(drop_a), 32'(drop));
        chk("ovf_cnt", 32'(ovf_a), 32'(ovf));
        chk("accept_cnt_sat", 32'(acc_b), sat3(acc));
        chk("drop_cnt_sat", 32'(drop_b), sat3(drop));
        chk("ovf_cnt_sat", 32'(ovf_b), sat3(ovf));
    endtask

    // Called at a negedge with the controller idle; returns at the negedge after DECIDE.
    task automatic do_rx(input logic [31:0] w, input logic pop);
        rx_valid = 1'b1;
        rx_word  = w;
        #1;
        chk("rx_ready", 32'(rx_ready_a), 32'd1);
        chk("rx_ready_b", 32'(rx_ready_b), 32'd1);
        @(negedge Clk);
        rx_valid = 1'b0;
        chk("lookup_lc_rd", 32'(lc_rd_a), 32'd1);
        chk("lookup_lc_wr", 32'(lc_wr_a), 32'd0);
        chk("lookup_label", 32'(lc_lbl_a), 32'(w[7:0]));
        @(negedge Clk);
        out_rd = pop;
        @(negedge Clk);
        out_rd = 1'b0;
    endtask

    task automatic do_cfg(input logic [7:0] l);
        cfg_req   = 1'b1;
        cfg_label = l;
        @(negedge Clk);
        cfg_req = 1'b0;
        chk("write_lc_wr", 32'(lc_wr_a), 32'd1);
        chk("write_cfg_ack", 32'(cfg_ack_a), 32'd1);
        chk("write_cfg_ack_b", 32'(cfg_ack_b), 32'd1);
        chk("write_label_adr", 32'(lc_adr_a), 32'(l));
        chk("write_lc_rd", 32'(lc_rd_a), 32'd0);
        @(negedge Clk);
        chk("cfg_ack_pulse", 32'(cfg_ack_a), 32'd0);
    endtask

    task automatic pop_chk(input logic [31:0] w);
        chk("pop_out_valid", 32'(out_valid_a), 32'd1);
        chk("pop_out_word", out_word_a, w);
        chk("pop_out_word_b", out_word_b, w);
        out_rd = 1'b1;
        @(negedge Clk);
        out_rd = 1'b0;
    endtask

    function automatic logic [31:0] wrap_word(input int i);
        return {8'hC0, 8'hDE, 8'(i), 8'h6A};
    endfunction

    typedef struct {
        bit          is_cfg;
        logic [31:0] word;
        bit          pop;
        bit          ov;
        bit          full;
        logic [31:0] head;
        int          acc;
        int          drop;
        int          ovf;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        bit exp_wr[10]  = '{0, 1, 0, 0, 0, 0, 1, 0, 0, 0};
        bit exp_rd[10]  = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
        bit exp_rdy[10] = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0};

        vecs[0]  = '{1'b1, 32'h0000_006A, 1'b0, 1'b0, 1'b0, 32'h0, 0, 0, 0};
        vecs[1]  = '{1'b0, 32'h1234_566A, 1'b0, 1'b1, 1'b0, 32'h1234_566A, 1, 0, 0};
        vecs[2]  = '{1'b0, 32'h0000_0010, 1'b0, 1'b1, 1'b0, 32'h1234_566A, 1, 1, 0};
        vecs[3]  = '{1'b0, 32'hAAAA_006A, 1'b0, 1'b1, 1'b0, 32'h1234_566A, 2, 1, 0};
        vecs[4]  = '{1'b0, 32'hBBBB_006A, 1'b0, 1'b1, 1'b0, 32'h1234_566A, 3, 1, 0};
        vecs[5]  = '{1'b0, 32'hCCCC_006A, 1'b0, 1'b1, 1'b1, 32'h1234_566A, 4, 1, 0};
        vecs[6]  = '{1'b0, 32'hDDDD_006A, 1'b0, 1'b1, 1'b1, 32'h1234_566A, 4, 1, 1};
        vecs[7]  = '{1'b0, 32'hEEEE_006A, 1'b1, 1'b1, 1'b1, 32'hAAAA_006A, 5, 1, 1};
        vecs[8]  = '{1'b0, 32'h0000_0011, 1'b1, 1'b1, 1'b0, 32'hBBBB_006A, 5, 2, 1};
        vecs[9]  = '{1'b0, 32'h0000_0020, 1'b0, 1'b1, 1'b0, 32'hBBBB_006A, 5, 3, 1};
        vecs[10] = '{1'b0, 32'h0000_007F, 1'b0, 1'b1, 1'b0, 32'hBBBB_006A, 5, 4, 1};
        vecs[11] = '{1'b0, 32'h0000_0110, 1'b0, 1'b1, 1'b0, 32'hBBBB_006A, 5, 5, 1};

        // Reset state
        @(negedge Clk);
        @(negedge Clk);
        chk("rst_rx_ready", 32'(rx_ready_a), 32'd0);
        chk("rst_out_valid", 32'(out_valid_a), 32'd0);
        chk("rst_fifo_full", 32'(fifo_full_a), 32'd0);
        chk("rst_cfg_ack", 32'(cfg_ack_a), 32'd0);
        chk("rst_lc_wr", 32'(lc_wr_a), 32'd0);
        chk("rst_lc_rd", 32'(lc_rd_a), 32'd0);
        chk_cnt(0, 0, 0);
        Rst = 1'b0;
        @(negedge Clk);
        chk("post_rst_rx_ready", 32'(rx_ready_a), 32'd1);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_cfg) do_cfg(vecs[i].word[7:0]);
            else do_rx(vecs[i].word, vecs[i].pop);
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid_a), 32'(vecs[i].ov));
            chk($sformatf("vec%0d_out_valid_b", i), 32'(out_valid_b), 32'(vecs[i].ov));
            chk($sformatf("vec%0d_fifo_full", i), 32'(fifo_full_a), 32'(vecs[i].full));
            chk($sformatf("vec%0d_fifo_full_b", i), 32'(fifo_full_b), 32'(vecs[i].full));
            if (vecs[i].ov) begin
                chk($sformatf("vec%0d_head", i), out_word_a, vecs[i].head);
                chk($sformatf("vec%0d_head_b", i), out_word_b, vecs[i].head);
            end
            chk_cnt(vecs[i].acc, vecs[i].drop, vecs[i].ovf);
        end

        // Drain, then pop on empty must be ignored
        pop_chk(32'hBBBB_006A);
        pop_chk(32'hCCCC_006A);
        pop_chk(32'hEEEE_006A);
        chk("drained_out_valid", 32'(out_valid_a), 32'd0);
        out_rd = 1'b1;
        @(negedge Clk);
        out_rd = 1'b0;
        chk("empty_pop_out_valid", 32'(out_valid_a), 32'd0);
        chk("empty_pop_fifo_full", 32'(fifo_full_a), 32'd0);

        // Pointer wrap: ten pushes, each overlapping a pop of the previous word
        do_rx(wrap_word(0), 1'b0);
        for (int i = 1; i < 10; i++) begin
            chk($sformatf("wrap%0d_head", i), out_word_a, wrap_word(i - 1));
            do_rx(wrap_word(i), 1'b1);
            chk($sformatf("wrap%0d_out_valid", i), 32'(out_valid_a), 32'd1);
            chk($sformatf("wrap%0d_fifo_full", i), 32'(fifo_full_a), 32'd0);
        end
        pop_chk(wrap_word(9));
        chk("wrap_out_valid", 32'(out_valid_a), 32'd0);
        chk_cnt(15, 5, 1);

        // Arbitration: both requests held, grants alternate cfg, rx, cfg, rx
        cfg_req   = 1'b1;
        cfg_label = 8'h22;
        rx_valid  = 1'b1;
        rx_word   = 32'h5555_5522;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("arb%0d_lc_wr", k), 32'(lc_wr_a), 32'(exp_wr[k]));
            chk($sformatf("arb%0d_cfg_ack", k), 32'(cfg_ack_a), 32'(exp_wr[k]));
            chk($sformatf("arb%0d_lc_rd", k), 32'(lc_rd_a), 32'(exp_rd[k]));
            chk($sformatf("arb%0d_rx_ready", k), 32'(rx_ready_a), 32'(exp_rdy[k]));
            chk($sformatf("arb%0d_wr_rd_excl", k), 32'(lc_wr_a & lc_rd_a), 32'd0);
            if (k == 9) begin
                cfg_req  = 1'b0;
                rx_valid = 1'b0;
            end
            @(negedge Clk);
        end
        pop_chk(32'h5555_5522);
        pop_chk(32'h5555_5522);
        chk_cnt(17, 5, 1);

        // Reset in the middle of a lookup
        rx_valid = 1'b1;
        rx_word  = 32'h7777_776A;
        @(negedge Clk);
        rx_valid = 1'b0;
        chk("pre_rst_lc_rd", 32'(lc_rd_a), 32'd1);
        #2;
        Rst = 1'b1;
        #1;
        chk("mid_rst_lc_rd", 32'(lc_rd_a), 32'd0);
        chk("mid_rst_lc_label_in", 32'(lc_lbl_a), 32'd0);
        chk("mid_rst_rx_ready", 32'(rx_ready_a), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid_a), 32'd0);
        chk_cnt(0, 0, 0);
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        chk("rel_rx_ready", 32'(rx_ready_a), 32'd1);
        chk("rel_lc_rd", 32'(lc_rd_a), 32'd0);
        chk("rel_out_valid", 32'(out_valid_a), 32'd0);
        chk_cnt(0, 0, 0);

        // Label table survives reset
        do_rx(32'h7777_776A, 1'b0);
        chk("post_rst_out_valid", 32'(out_valid_a), 32'd1);
        chk("post_rst_out_word", out_word_a, 32'h7777_776A);
        chk_cnt(1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
